la_capture_core: RTL and testbench

LA_CAPTURE_CORE -- requirements
Module: la_capture_core

---
 rtl/la_capture_core.sv | 167 ++++++++++++++++
 tb/tb_la_capture_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// Logic-analyser capture core. Samples qualified probe data into a circular
// buffer, waits for a trigger after filling the requested pre-trigger window,
// collects the remaining post-trigger samples, then freezes the buffer for
// readout. trig_addr_o / start_addr_o locate the trigger and oldest sample.
module la_capture_core #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sample_en_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_addr_o,
    output logic [AW-1:0]     start_addr_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0]        state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       cnt_reg;       // pre samples in PRE, post samples in POST
    logic [AW-1:0]     pretrig_reg;
    logic [1:0]        mode_reg;
    logic [DATA_W-1:0] value_reg;
    logic [DATA_W-1:0] mask_reg;
    logic              match_q;
    logic              first_q;

    logic              capturing;
    logic              qual;
    logic              match;
    logic              trig;
    logic [AW:0]       post_total;

    // Sample qualification, compare and trigger decision for the current sample
    always_comb begin
        capturing  = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
        qual       = capturing && sample_en_i && !abort_i;
        match      = ((data_i ^ value_reg) & mask_reg) == '0;
        post_total = (AW+1)'(DEPTH) - {1'b0, pretrig_reg};
        trig       = 1'b0;
        case (mode_reg)
            2'b00:   trig = match;
            2'b01:   trig = match && !match_q && !first_q;
            2'b10:   trig = !match && match_q && !first_q;
            default: trig = 1'b1;
        endcase
    end

    // Capture FSM, pointers, trigger bookkeeping and done flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            pretrig_reg  <= '0;
            mode_reg     <= 2'b00;
            value_reg    <= '0;
            mask_reg     <= '0;
            match_q      <= 1'b0;
            first_q      <= 1'b1;
            done_o       <= 1'b0;
            trig_addr_o  <= '0;
            start_addr_o <= '0;
        end else begin
            if (abort_i) begin
                state_reg <= ST_IDLE;
                done_o    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            // pretrig_i is AW bits wide, so it never exceeds DEPTH-1
                            pretrig_reg <= pretrig_i;
                            mode_reg    <= trig_mode_i;
                            value_reg   <= trig_value_i;
                            mask_reg    <= trig_mask_i;
                            wr_ptr_reg  <= '0;
                            cnt_reg     <= '0;
                            done_o      <= 1'b0;
                            first_q     <= 1'b1;
                            state_reg   <= (pretrig_i == '0) ? ST_WAIT : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (qual) begin
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg + 1'b1 == {1'b0, pretrig_reg}) begin
                                state_reg <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (qual && trig) begin
                            trig_addr_o  <= wr_ptr_reg;
                            start_addr_o <= wr_ptr_reg - pretrig_reg;
                            cnt_reg      <= {{AW{1'b0}}, 1'b1};
                            if (post_total == {{AW{1'b0}}, 1'b1}) begin
                                state_reg <= ST_DONE;
                                done_o    <= 1'b1;
                            end else begin
                                state_reg <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (qual) begin
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg + 1'b1 == post_total) begin
                                state_reg <= ST_DONE;
                                done_o    <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
            if (qual) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                match_q    <= match;
                first_q    <= 1'b0;
            end
        end
    end

    // Sample buffer write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk_i) begin
        if (qual) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    // Registered read port; same-address write returns the previous word
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= mem[rd_addr_i];
            end
        end
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core (DATA_W=8, DEPTH=16): directed sequences, a
// table-driven readout and randomized captures against a sample-list model.
module tb_la_capture_core;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [DW-1:0] data_i;
    logic          sample_en_i;
    logic          arm_i;
    logic          abort_i;
    logic [1:0]    trig_mode_i;
    logic [DW-1:0] trig_value_i;
    logic [DW-1:0] trig_mask_i;
    logic [AW-1:0] pretrig_i;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic [2:0]    state_o;
    logic          done_o;
    logic [AW-1:0] trig_addr_o;
    logic [AW-1:0] start_addr_o;

    always #5 clk = ~clk;

    la_capture_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i), .sample_en_i(sample_en_i),
        .arm_i(arm_i), .abort_i(abort_i), .trig_mode_i(trig_mode_i),
        .trig_value_i(trig_value_i), .trig_mask_i(trig_mask_i), .pretrig_i(pretrig_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .state_o(state_o), .done_o(done_o),
        .trig_addr_o(trig_addr_o), .start_addr_o(start_addr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the list of qualified samples since arm, plus settings
    logic [7:0] q[$];
    int         m_pre;
    logic [1:0] m_mode;
    logic [7:0] m_val;
    logic [7:0] m_mask;
    int         m_trig;
    bit         m_armed  = 0;
    bit         m_active = 0;

    function automatic bit mmatch(input logic [7:0] d);
        return ((d ^ m_val) & m_mask) == 8'h00;
    endfunction

    function automatic logic [2:0] exp_state();
        if (!m_armed) return 3'd0;
        if (!m_active) return 3'd4;
        if (m_trig < 0) return (q.size() < m_pre) ? 3'd1 : 3'd2;
        return 3'd3;
    endfunction

    task automatic model_sample(input logic [7:0] d);
        int idx;
        bit t;
        idx = q.size();
        q.push_back(d);
        t = 0;
        if (m_trig < 0 && idx >= m_pre) begin
            case (m_mode)
                2'd0:    t = mmatch(d);
                2'd1:    t = (idx > 0) && mmatch(d) && !mmatch(q[idx-1]);
                2'd2:    t = (idx > 0) && !mmatch(d) && mmatch(q[idx-1]);
                default: t = 1;
            endcase
            if (t) m_trig = idx;
        end
        if (m_trig >= 0 && q.size() == m_trig + DEPTH - m_pre) m_active = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] d, input bit en);
        bit do_s;
        data_i      = d;
        sample_en_i = en;
        do_s        = m_armed && m_active && en;
        tick();
        if (do_s) model_sample(d);
        chk("state", {61'd0, state_o}, {61'd0, exp_state()});
        chk("done", {63'd0, done_o}, {63'd0, (m_armed && !m_active)});
    endtask

    task automatic arm(input int pre, input logic [1:0] mode, input logic [7:0] val,
                       input logic [7:0] mask, input logic [7:0] d);
        pretrig_i    = AW'(pre);
        trig_mode_i  = mode;
        trig_value_i = val;
        trig_mask_i  = mask;
        data_i       = d;
        sample_en_i  = 1'b1;
        arm_i        = 1'b1;
        tick();
        arm_i    = 1'b0;
        q.delete();
        m_pre    = pre;
        m_mode   = mode;
        m_val    = val;
        m_mask   = mask;
        m_trig   = -1;
        m_armed  = 1;
        m_active = 1;
        chk("arm_state", {61'd0, state_o}, {61'd0, exp_state()});
        chk("arm_done", {63'd0, done_o}, 64'd0);
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        sample_en_i = 1'b0;
        tick();
        abort_i = 1'b0;
        m_armed = 0;
        chk("abort_state", {61'd0, state_o}, 64'd0);
        chk("abort_done", {63'd0, done_o}, 64'd0);
    endtask

    task automatic rd(input int addr, input logic [7:0] exp);
        rd_addr_i   = AW'(addr);
        rd_en_i     = 1'b1;
        sample_en_i = 1'b0;
        tick();
        rd_en_i = 1'b0;
        chk("rd_valid", {63'd0, rd_valid_o}, 64'd1);
        chk("rd_data", {56'd0, rd_data_o}, {56'd0, exp});
    endtask

    // Compare pointers and the whole frozen buffer with the model's last DEPTH samples
    task automatic check_capture();
        int st;
        st = (m_trig - m_pre) % DEPTH;
        chk("trig_addr", {60'd0, trig_addr_o}, 64'(m_trig % DEPTH));
        chk("start_addr", {60'd0, start_addr_o}, 64'(st));
        for (int i = 0; i < DEPTH; i++) begin
            rd((st + i) % DEPTH, q[m_trig - m_pre + i]);
        end
    endtask

    typedef struct {
        logic       rd_en;
        logic [3:0] addr;
        logic       exp_valid;
        logic [7:0] exp_data;
    } rd_vec_t;

    rd_vec_t tbl[18];

    initial begin
        int trig_cyc;
        int done_cyc;
        int cyc;
        logic [7:0] d;

        // Ramp capture readout: start_addr 12 holds 0x1C, wrapping through 0x2B
        for (int i = 0; i < 16; i++) begin
            tbl[i].rd_en     = 1'b1;
            tbl[i].addr      = 4'((12 + i) % 16);
            tbl[i].exp_valid = 1'b1;
            tbl[i].exp_data  = 8'(8'h1C + i);
        end
        tbl[16].rd_en = 1'b0; tbl[16].addr = 4'd0; tbl[16].exp_valid = 1'b0; tbl[16].exp_data = 8'h00;
        tbl[17].rd_en = 1'b1; tbl[17].addr = 4'd0; tbl[17].exp_valid = 1'b1; tbl[17].exp_data = 8'h20;

        rst_n_i = 1'b0; data_i = '0; sample_en_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0;
        trig_mode_i = 2'd0; trig_value_i = '0; trig_mask_i = '0; pretrig_i = '0;
        rd_en_i = 1'b0; rd_addr_i = '0;
        tick();
        tick();
        chk("rst_state", {61'd0, state_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid_o}, 64'd0);
        chk("rst_rd_data", {56'd0, rd_data_o}, 64'd0);
        chk("rst_trig_addr", {60'd0, trig_addr_o}, 64'd0);
        chk("rst_start_addr", {60'd0, start_addr_o}, 64'd0);
        rst_n_i = 1'b1;
        tick();

        // Ramp data, pretrig 4, level match on 0x20
        arm(4, 2'd0, 8'h20, 8'hFF, 8'h0F);
        d = 8'h10; trig_cyc = -1; done_cyc = -1; cyc = 0;
        while (m_active && cyc < 60) begin
            step(d, 1'b1);
            if (trig_cyc < 0 && state_o == 3'd3) trig_cyc = cyc;
            if (done_cyc < 0 && done_o) done_cyc = cyc;
            d++;
            cyc++;
        end
        chk("r32_post_span", 64'(done_cyc - trig_cyc), 64'd11);
        chk("r32_trig_addr", {60'd0, trig_addr_o}, 64'd0);
        chk("r32_start_addr", {60'd0, start_addr_o}, 64'd12);
        for (int i = 0; i < 3; i++) step(8'h55, 1'b1);
        chk("r32_hold_trig", {60'd0, trig_addr_o}, 64'd0);
        for (int i = 0; i < 18; i++) begin
            rd_en_i = tbl[i].rd_en;
            rd_addr_i = tbl[i].addr;
            sample_en_i = 1'b0;
            tick();
            chk("r32_tbl_valid", {63'd0, rd_valid_o}, {63'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk("r32_tbl_data", {56'd0, rd_data_o}, {56'd0, tbl[i].exp_data});
        end
        rd_en_i = 1'b0;

        // Onset mode: the first sample may not trigger even though it matches
        arm(0, 2'd1, 8'h01, 8'h01, 8'h01);
        step(8'h01, 1'b1);
        chk("r33_no_first", {61'd0, state_o}, 64'd2);
        step(8'h00, 1'b1);
        step(8'h01, 1'b1);
        chk("r33_onset", {61'd0, state_o}, 64'd3);
        chk("r33_trig_addr", {60'd0, trig_addr_o}, 64'd2);
        do_abort();

        // Immediate mode with sample_en toggling
        arm(0, 2'd3, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 32; c++) step(8'(c), (c % 2) == 0);
        chk("r34_state", {61'd0, state_o}, 64'd4);
        chk("r34_done", {63'd0, done_o}, 64'd1);
        chk("r34_trig_addr", {60'd0, trig_addr_o}, 64'd0);
        // Read of address 5 in DONE: 6th qualified sample, data 10
        rd(5, 8'd10);
        tick();
        chk("r37_valid_drop", {63'd0, rd_valid_o}, 64'd0);

        // Maximum pretrig, trigger after 40 non-matching samples
        arm(15, 2'd0, 8'hAA, 8'hFF, 8'h00);
        for (int i = 0; i < 40; i++) step(8'(i), 1'b1);
        step(8'hAA, 1'b0);
        chk("r35_unqualified", {61'd0, state_o}, 64'd2);
        step(8'hAA, 1'b1);
        chk("r35_state", {61'd0, state_o}, 64'd4);
        chk("r35_trig", {60'd0, trig_addr_o}, 64'd8);
        chk("r35_start", {60'd0, start_addr_o}, 64'd9);
        check_capture();

        // Abort beats arm in WAIT
        arm(2, 2'd0, 8'hFF, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
        chk("r36_wait", {61'd0, state_o}, 64'd2);
        arm_i = 1'b1;
        do_abort();
        arm_i = 1'b0;
        tick();
        chk("r36_stay_idle", {61'd0, state_o}, 64'd0);

        // Asynchronous reset in POST
        arm(0, 2'd3, 8'h00, 8'h00, 8'h00);
        rd_en_i = 1'b1;
        step(8'h33, 1'b1);
        rd_en_i = 1'b0;
        chk("r36_post", {61'd0, state_o}, 64'd3);
        chk("r36_rdv_pre", {63'd0, rd_valid_o}, 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("r36_rst_state", {61'd0, state_o}, 64'd0);
        chk("r36_rst_done", {63'd0, done_o}, 64'd0);
        chk("r36_rst_rdv", {63'd0, rd_valid_o}, 64'd0);
        chk("r36_rst_rdd", {56'd0, rd_data_o}, 64'd0);
        chk("r36_rst_trig", {60'd0, trig_addr_o}, 64'd0);
        chk("r36_rst_start", {60'd0, start_addr_o}, 64'd0);
        m_armed = 0;
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 20; i++) step(8'h00, 1'b1);

        // Randomized captures, re-armed from DONE or after abort
        for (int r = 0; r < 10; r++) begin
            int pre;
            logic [7:0] mask;
            pre  = $urandom_range(0, 15);
            mask = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
            arm(pre, 2'($urandom_range(0, 3)), 8'($urandom), mask, 8'($urandom));
            cyc = 0;
            while (m_active && cyc < 400) begin
                step(8'($urandom), $urandom_range(0, 3) != 0);
                cyc++;
            end
            if (!m_active) check_capture();
            else do_abort();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
